// File: rtl/cpu_memwb_if.sv
// Memory bus between the MEM/WB stage and the data memory.
// The master (cpu_memwb) raises mem_req_o and holds address/data/direction
// until the slave returns a one-cycle mem_ack_i (with mem_dat_i for reads).
interface cpu_memwb_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [31:0] mem_dat_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_adr_o,
        output mem_dat_o,
        input  mem_dat_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_adr_o,
        input  mem_dat_o,
        output mem_dat_i,
        output mem_ack_i
    );
endinterface

// File: rtl/cpu_memwb.sv
// Memory / write-back stage.
// Launches loads and stores on the memory bus, stalls upstream while a bus
// transaction is outstanding, and retires ALU results and load data to the
// register file with a one-cycle write strobe.
// Optional: define MOXIE_MEMWB_TIMEOUT_EN to abort a bus transaction that
// sees no acknowledge within 15 wait cycles and flag it on bus_error_o.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accepting upstream inputs; no bus transaction outstanding
// MEM_WAIT | bus request held, waiting for mem_ack_i; inputs ignored
module cpu_memwb (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  register_write_index_i,
    input  logic        register_write_enable_i,
    input  logic        memory_write_enable_i,
    input  logic        memory_read_enable_i,
    input  logic [31:0] memory_address_i,
    input  logic [31:0] result_i,
    cpu_memwb_if.master bus,
    output logic        reg_write_enable_o,
    output logic [3:0]  reg_write_index_o,
    output logic [31:0] reg_write_data_o,
    output logic        stall_o
`ifdef MOXIE_MEMWB_TIMEOUT_EN
    ,
    output logic        bus_error_o
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] load_idx;
    // A read with a simultaneous store is dropped, so only a lone read
    // claims the register-file port for the load result.
    logic       load_req;

`ifdef MOXIE_MEMWB_TIMEOUT_EN
    logic [3:0] wait_cnt;
`endif

    assign load_req = memory_read_enable_i & ~memory_write_enable_i;

    // Upstream must hold while a transaction is outstanding, including the ack cycle.
    assign stall_o = (state == MEM_WAIT);

    // Stage FSM: bus request launch/hold, load target capture and register writes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= IDLE;
            bus.mem_req_o      <= 1'b0;
            bus.mem_we_o       <= 1'b0;
            bus.mem_adr_o      <= 32'h0;
            bus.mem_dat_o      <= 32'h0;
            load_idx           <= 4'h0;
            reg_write_enable_o <= 1'b0;
            reg_write_index_o  <= 4'h0;
            reg_write_data_o   <= 32'h0;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
            wait_cnt           <= 4'h0;
            bus_error_o        <= 1'b0;
`endif
        end else begin
            reg_write_enable_o <= 1'b0;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
            bus_error_o        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (memory_write_enable_i) begin
                        state         <= MEM_WAIT;
                        bus.mem_req_o <= 1'b1;
                        bus.mem_we_o  <= 1'b1;
                        bus.mem_adr_o <= memory_address_i;
                        bus.mem_dat_o <= result_i;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
                        wait_cnt      <= 4'h0;
`endif
                    end else if (memory_read_enable_i) begin
                        state         <= MEM_WAIT;
                        bus.mem_req_o <= 1'b1;
                        bus.mem_we_o  <= 1'b0;
                        bus.mem_adr_o <= memory_address_i;
                        load_idx      <= register_write_index_i;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
                        wait_cnt      <= 4'h0;
`endif
                    end
                    if (register_write_enable_i && !load_req) begin
                        reg_write_enable_o <= 1'b1;
                        reg_write_index_o  <= register_write_index_i;
                        reg_write_data_o   <= result_i;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack_i) begin
                        state         <= IDLE;
                        bus.mem_req_o <= 1'b0;
                        if (!bus.mem_we_o) begin
                            reg_write_enable_o <= 1'b1;
                            reg_write_index_o  <= load_idx;
                            reg_write_data_o   <= bus.mem_dat_i;
                        end
                    end
`ifdef MOXIE_MEMWB_TIMEOUT_EN
                    // Fifteenth wait cycle without ack: give up, no register write.
                    else if (wait_cnt == 4'd14) begin
                        state         <= IDLE;
                        bus.mem_req_o <= 1'b0;
                        bus_error_o   <= 1'b1;
                        wait_cnt      <= 4'd15;
                    end else begin
                        wait_cnt      <= wait_cnt + 4'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_memwb.sv
// Directed bench for cpu_memwb with a transaction-level reference model and
// a per-cycle compare process, plus literal checks on the key scenarios.
module tb_cpu_memwb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  register_write_index_i = 4'h0;
    logic        register_write_enable_i = 1'b0;
    logic        memory_write_enable_i = 1'b0;
    logic        memory_read_enable_i = 1'b0;
    logic [31:0] memory_address_i = 32'h0;
    logic [31:0] result_i = 32'h0;
    logic        reg_write_enable_o;
    logic [3:0]  reg_write_index_o;
    logic [31:0] reg_write_data_o;
    logic        stall_o;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
    logic        bus_error_o;
`endif

    cpu_memwb_if bus ();

    cpu_memwb dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .register_write_index_i  (register_write_index_i),
        .register_write_enable_i (register_write_enable_i),
        .memory_write_enable_i   (memory_write_enable_i),
        .memory_read_enable_i    (memory_read_enable_i),
        .memory_address_i        (memory_address_i),
        .result_i                (result_i),
        .bus                     (bus),
        .reg_write_enable_o      (reg_write_enable_o),
        .reg_write_index_o       (reg_write_index_o),
        .reg_write_data_o        (reg_write_data_o),
        .stall_o                 (stall_o)
`ifdef MOXIE_MEMWB_TIMEOUT_EN
        ,
        .bus_error_o             (bus_error_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding bus transaction at most; everything else is derived
    // from "is a transaction pending" plus the transaction record.
    typedef struct {
        bit          is_store;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  tgt;
    } txn_t;

    bit          m_busy = 1'b0;
    bit          m_rst = 1'b1;
    txn_t        m_txn;
    int          m_wait = 0;
    logic        e_req = 1'b0, e_we = 1'b0, e_rwe = 1'b0, e_berr = 1'b0;
    logic [31:0] e_adr = 32'h0, e_dat = 32'h0, e_rdat = 32'h0;
    logic [3:0]  e_idx = 4'h0;

    task automatic model_step();
        if (!rst_i) begin
            m_rst = 1'b1; m_busy = 1'b0; m_wait = 0;
            e_req = 0; e_we = 0; e_adr = 0; e_dat = 0;
            e_rwe = 0; e_idx = 0; e_rdat = 0; e_berr = 0;
            return;
        end
        m_rst = 1'b0;
        e_rwe = 1'b0;
        e_berr = 1'b0;
        if (!m_busy) begin
            if (memory_write_enable_i || memory_read_enable_i) begin
                m_busy = 1'b1;
                m_wait = 0;
                m_txn.is_store = memory_write_enable_i;
                m_txn.adr = memory_address_i;
                m_txn.dat = result_i;
                m_txn.tgt = register_write_index_i;
                e_req = 1'b1;
                e_we = memory_write_enable_i;
                e_adr = memory_address_i;
                if (memory_write_enable_i) e_dat = result_i;
            end
            if (register_write_enable_i && !(memory_read_enable_i && !memory_write_enable_i)) begin
                e_rwe = 1'b1;
                e_idx = register_write_index_i;
                e_rdat = result_i;
            end
        end else if (bus.mem_ack_i) begin
            m_busy = 1'b0;
            e_req = 1'b0;
            if (!m_txn.is_store) begin
                e_rwe = 1'b1;
                e_idx = m_txn.tgt;
                e_rdat = bus.mem_dat_i;
            end
        end else begin
            m_wait++;
`ifdef MOXIE_MEMWB_TIMEOUT_EN
            if (m_wait == 15) begin
                m_busy = 1'b0;
                e_req = 1'b0;
                e_berr = 1'b1;
            end
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_i);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (cmp_en) begin
                chk("stall", {31'h0, stall_o}, {31'h0, m_busy});
                chk("mem_req", {31'h0, bus.mem_req_o}, {31'h0, e_req});
                chk("reg_we", {31'h0, reg_write_enable_o}, {31'h0, e_rwe});
`ifdef MOXIE_MEMWB_TIMEOUT_EN
                chk("bus_error", {31'h0, bus_error_o}, {31'h0, e_berr});
`endif
                if (e_req || m_rst) begin
                    chk("mem_we", {31'h0, bus.mem_we_o}, {31'h0, e_we});
                    chk("mem_adr", bus.mem_adr_o, e_adr);
                end
                if ((e_req && e_we) || m_rst)
                    chk("mem_dat", bus.mem_dat_o, e_dat);
                if (e_rwe || m_rst) begin
                    chk("reg_idx", {28'h0, reg_write_index_o}, {28'h0, e_idx});
                    chk("reg_data", reg_write_data_o, e_rdat);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_in();
        register_write_enable_i = 1'b0;
        memory_write_enable_i = 1'b0;
        memory_read_enable_i = 1'b0;
        register_write_index_i = 4'h0;
        memory_address_i = 32'h0;
        result_i = 32'h0;
    endtask

    task automatic drive(input bit rwe, input bit mwe, input bit mre,
                         input logic [3:0] idx, input logic [31:0] adr, input logic [31:0] res);
        register_write_enable_i = rwe;
        memory_write_enable_i = mwe;
        memory_read_enable_i = mre;
        register_write_index_i = idx;
        memory_address_i = adr;
        result_i = res;
    endtask

    task automatic ack_pulse(input logic [31:0] d);
        bus.mem_ack_i = 1'b1;
        bus.mem_dat_i = d;
        tick();
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = 32'h0;
    endtask

    initial begin
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = 32'h0;
        rst_i = 1'b0;
        @(posedge clk_i);
        cmp_en = 1'b1;
        tick(); tick();
        // reset values
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("rst_rdat", reg_write_data_o, 32'h0);
        rst_i = 1'b1;
        tick();

        // ALU write
        drive(1, 0, 0, 4'd5, 32'h0, 32'h12345678);
        tick();
        clr_in();
        chk("alu_we", {31'h0, reg_write_enable_o}, 32'h1);
        chk("alu_idx", {28'h0, reg_write_index_o}, 32'd5);
        chk("alu_data", reg_write_data_o, 32'h12345678);
        chk("alu_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("alu_we_once", {31'h0, reg_write_enable_o}, 32'h0);

        // Store, ack on the fourth wait cycle
        drive(0, 1, 0, 4'd0, 32'h1000, 32'hDEADBEEF);
        tick();
        clr_in();
        for (int i = 0; i < 3; i++) begin
            chk("st_req", {31'h0, bus.mem_req_o}, 32'h1);
            chk("st_adr", bus.mem_adr_o, 32'h1000);
            chk("st_dat", bus.mem_dat_o, 32'hDEADBEEF);
            tick();
        end
        chk("st_ack_stall", {31'h0, stall_o}, 32'h1);
        chk("st_ack_we", {31'h0, bus.mem_we_o}, 32'h1);
        ack_pulse(32'h0);
        chk("st_done_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("st_done_rwe", {31'h0, reg_write_enable_o}, 32'h0);
        tick();

        // Load; upstream churns during the wait and must be ignored
        drive(0, 0, 1, 4'd3, 32'h2000, 32'h0);
        tick();
        drive(1, 1, 1, 4'd9, 32'hBAD0, 32'h11111111);
        tick();
        chk("ld_adr", bus.mem_adr_o, 32'h2000);
        chk("ld_we", {31'h0, bus.mem_we_o}, 32'h0);
        ack_pulse(32'hCAFEF00D);
        clr_in();
        chk("ld_rwe", {31'h0, reg_write_enable_o}, 32'h1);
        chk("ld_idx", {28'h0, reg_write_index_o}, 32'd3);
        chk("ld_data", reg_write_data_o, 32'hCAFEF00D);
        tick();

        // Back-to-back: store then held ALU write to r2
        drive(0, 1, 0, 4'd0, 32'h3000, 32'h00000055);
        tick();
        drive(1, 0, 0, 4'd2, 32'h0, 32'hA5A5A5A5);
        tick();
        ack_pulse(32'h0);
        chk("b2b_idle", {31'h0, stall_o}, 32'h0);
        chk("b2b_early", {31'h0, reg_write_enable_o}, 32'h0);
        tick();
        clr_in();
        chk("b2b_rwe", {31'h0, reg_write_enable_o}, 32'h1);
        chk("b2b_idx", {28'h0, reg_write_index_o}, 32'd2);
        chk("b2b_data", reg_write_data_o, 32'hA5A5A5A5);
        tick();

        // Both enables plus ALU write: store wins, ALU write retires alongside
        drive(1, 1, 1, 4'd7, 32'h4444, 32'h77777777);
        tick();
        clr_in();
        chk("both_we", {31'h0, bus.mem_we_o}, 32'h1);
        chk("both_rwe", {31'h0, reg_write_enable_o}, 32'h1);
        chk("both_idx", {28'h0, reg_write_index_o}, 32'd7);
        ack_pulse(32'h99999999);
        chk("both_no_ld", {31'h0, reg_write_enable_o}, 32'h0);

        // Ack while idle is ignored
        ack_pulse(32'h12121212);
        chk("idle_ack_rwe", {31'h0, reg_write_enable_o}, 32'h0);
        chk("idle_ack_req", {31'h0, bus.mem_req_o}, 32'h0);

`ifndef MOXIE_MEMWB_TIMEOUT_EN
        // Without the timeout the stage waits indefinitely
        drive(0, 0, 1, 4'd6, 32'h6000, 32'h0);
        tick();
        clr_in();
        repeat (20) tick();
        chk("nto_stall", {31'h0, stall_o}, 32'h1);
        chk("nto_req", {31'h0, bus.mem_req_o}, 32'h1);
        ack_pulse(32'h0BADF00D);
        chk("nto_rwe", {31'h0, reg_write_enable_o}, 32'h1);
        chk("nto_data", reg_write_data_o, 32'h0BADF00D);
        tick();
`endif

        // Reset in the middle of a load, ack after release is ignored
        drive(0, 0, 1, 4'd4, 32'h5000, 32'h0);
        tick();
        clr_in();
        tick();
        rst_i = 1'b0;
        #1;
        chk("mr_stall", {31'h0, stall_o}, 32'h0);
        chk("mr_req", {31'h0, bus.mem_req_o}, 32'h0);
        chk("mr_adr", bus.mem_adr_o, 32'h0);
        tick();
        rst_i = 1'b1;
        ack_pulse(32'hFFFFFFFF);
        chk("mr_no_rwe", {31'h0, reg_write_enable_o}, 32'h0);
        chk("mr_no_req", {31'h0, bus.mem_req_o}, 32'h0);
        tick();

`ifdef MOXIE_MEMWB_TIMEOUT_EN
        // Load with no ack: 15 wait cycles, then a single bus_error pulse
        begin
            int stall_cycles = 0;
            int errs = 0;
            bit done = 1'b0;
            drive(0, 0, 1, 4'd8, 32'h7000, 32'h0);
            tick();
            clr_in();
            for (int i = 0; i < 40 && !done; i++) begin
                if (stall_o) stall_cycles++;
                else done = 1'b1;
                if (!done) tick();
            end
            if (!done) chk("to_bound", 32'h0, 32'h1);
            chk("to_cycles", stall_cycles, 32'd15);
            chk("to_berr", {31'h0, bus_error_o}, 32'h1);
            chk("to_req", {31'h0, bus.mem_req_o}, 32'h0);
            chk("to_rwe", {31'h0, reg_write_enable_o}, 32'h0);
            for (int i = 0; i < 3; i++) begin
                tick();
                if (bus_error_o) errs++;
            end
            chk("to_pulse_once", errs, 32'h0);
        end
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/cpu_memwb.md
CPU_MEMWB -- requirements
Module: cpu_memwb

Interface
REQ-001 clk_i  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset; asynchronous, active-low.
REQ-003 register_write_index_i  input  4  destination register from execute.
REQ-004 register_write_enable_i  input  1  execute result targets a register.
REQ-005 memory_write_enable_i  input  1  store request from execute.
REQ-006 memory_read_enable_i  input  1  load request from execute.
REQ-007 memory_address_i  input  32  load/store address.
REQ-008 result_i  input  32  ALU result, or store data.
REQ-009 mem_req_o  output  1  bus request, held until acknowledged.
REQ-010 mem_we_o  output  1  1 = write, 0 = read.
REQ-011 mem_adr_o  output  32  bus address.
REQ-012 mem_dat_o  output  32  bus write data.
REQ-013 mem_dat_i  input  32  bus read data, valid with mem_ack_i.
REQ-014 mem_ack_i  input  1  bus acknowledge, single-cycle pulse.
REQ-015 reg_write_enable_o  output  1  register-file write strobe.
REQ-016 reg_write_index_o  output  4  register-file write index.
REQ-017 reg_write_data_o  output  32  register-file write data.
REQ-018 stall_o  output  1  upstream holds its outputs while high.
REQ-019 bus_error_o  output  1  one-cycle pulse on bus timeout; exists only with REQ-036.

Function
REQ-020 The FSM SHALL have two states, IDLE and MEM_WAIT; stall_o SHALL be the combinational decode (state == MEM_WAIT).
REQ-021 Inputs SHALL be sampled only in IDLE; all inputs SHALL be ignored in MEM_WAIT.
REQ-022 IDLE, memory_write_enable_i=1: at the next edge, mem_req_o=1, mem_we_o=1, mem_adr_o=memory_address_i, mem_dat_o=result_i, state -> MEM_WAIT.
REQ-023 IDLE, memory_read_enable_i=1 and memory_write_enable_i=0: at the next edge, mem_req_o=1, mem_we_o=0, mem_adr_o=memory_address_i, register_write_index_i latched as load target, state -> MEM_WAIT.
REQ-024 Both memory enables high: the store SHALL win and the read SHALL be dropped.
REQ-025 IDLE, register_write_enable_i=1, no read: at the next edge, reg_write_enable_o=1, reg_write_index_o=register_write_index_i, reg_write_data_o=result_i (latency 1); this SHALL also apply alongside a store.
REQ-026 reg_write_enable_o SHALL be high for exactly one cycle per write.
REQ-027 MEM_WAIT: mem_req_o, mem_we_o, mem_adr_o and mem_dat_o SHALL stay stable until the cycle in which mem_ack_i=1.
REQ-028 On mem_ack_i in MEM_WAIT: at the next edge, mem_req_o=0 and state -> IDLE.
REQ-029 For a read, that same edge SHALL also set reg_write_enable_o=1, reg_write_data_o=mem_dat_i and reg_write_index_o=latched target.
REQ-030 stall_o SHALL remain high during the ack cycle, so the held upstream instruction is accepted in the first IDLE cycle.
REQ-031 mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-032 While rst_i=0, state SHALL be IDLE.
REQ-033 While rst_i=0, mem_req_o, mem_we_o, reg_write_enable_o, stall_o and bus_error_o SHALL be 0.
REQ-034 While rst_i=0, mem_adr_o, mem_dat_o, reg_write_index_o and reg_write_data_o SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no register write; a later ack SHALL be ignored.

Configuration
REQ-036 With MOXIE_MEMWB_TIMEOUT_EN defined: a 4-bit counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-037 With MOXIE_MEMWB_TIMEOUT_EN defined: after 15 cycles without ack, the next edge SHALL set mem_req_o=0, state -> IDLE, bus_error_o=1 for one cycle, and perform no register write.
REQ-038 Without MOXIE_MEMWB_TIMEOUT_EN: MEM_WAIT SHALL wait indefinitely, bus_error_o SHALL not exist, and the counter SHALL not be built.

Verification
REQ-039 ALU write: register_write_enable_i=1, index 5, result_i=0x12345678 -> next cycle reg_write_enable_o=1 for one cycle, index 5, data 0x12345678, stall_o=0.
REQ-040 Store: memory_write_enable_i=1, address 0x1000, result_i=0xDEADBEEF, ack after 3 cycles -> mem_req_o/mem_we_o high with address and data stable for 4 cycles, stall_o high through the ack cycle, no register write.
REQ-041 Load: memory_read_enable_i=1, address 0x2000, index 3, ack with mem_dat_i=0xCAFEF00D -> the cycle after ack, reg_write_enable_o=1, index 3, data 0xCAFEF00D.
REQ-042 Back-to-back: a store followed by a held ALU write to index 2 -> the ALU write retires exactly one cycle after the store returns to IDLE.
REQ-043 Reset mid-load: rst_i=0 during MEM_WAIT, then an ack after reset release -> all outputs 0, no register write.
REQ-044 Timeout (MOXIE_MEMWB_TIMEOUT_EN defined): load with no ack -> after 15 wait cycles, bus_error_o pulses once, mem_req_o=0, stall_o=0, no register write.
